pwm_ramp_ctrl: RTL and testbench



---
 rtl/pwm_ramp_ctrl.sv | 143 ++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop duty sequencer in front of an 8-bit PWM generator.
// Ports: clk, rst (sync, active-high); tgt_duty/tgt_vld/tgt_rdy target
// handshake; estop level override; duty registered PWM duty; ramping,
// done (1-cycle completion pulse), prd_tick (period boundary strobe).
module pwm_ramp_ctrl #(
  parameter logic [7:0] STEP     = 8'd16,
  parameter int         RATE_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tgt_duty,
  input  logic       tgt_vld,
  output logic       tgt_rdy,
  input  logic       estop,
  output logic [7:0] duty,
  output logic       ramping,
  output logic       done,
  output logic       prd_tick
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_HOLD,
    S_STOP
  } state_t;

  localparam logic [3:0] DIV_LAST = 4'(RATE_DIV - 1);

  state_t     r_state;
  logic [7:0] r_duty;
  logic [7:0] r_tgt;
  logic [7:0] r_prd_cnt;
  logic [3:0] r_div_cnt;
  logic       r_rdy;
  logic       r_done;

  logic       w_tick;
  logic       w_upd;
  logic       w_acc;
  logic [8:0] w_up_gap;
  logic [8:0] w_dn_gap;
  logic [8:0] w_step9;

  assign w_tick   = (r_prd_cnt == 8'hFF);
  assign w_upd    = w_tick && (r_div_cnt == DIV_LAST);
  assign w_acc    = tgt_vld && r_rdy && !estop;
  // 9-bit gaps: a gap within one STEP clamps to the target,
  // so duty can neither overshoot nor wrap.
  assign w_up_gap = {1'b0, r_tgt} - {1'b0, r_duty};
  assign w_dn_gap = {1'b0, r_duty} - {1'b0, r_tgt};
  assign w_step9  = {1'b0, STEP};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_duty    <= 8'h00;
      r_tgt     <= 8'h00;
      r_prd_cnt <= 8'h00;
      r_div_cnt <= 4'h0;
      r_rdy     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_prd_cnt <= r_prd_cnt + 8'h01;
      r_done    <= 1'b0;

      // A fresh target restarts the update divider.
      if (w_acc)
        r_div_cnt <= 4'h0;
      else if (w_tick)
        r_div_cnt <= (r_div_cnt == DIV_LAST) ? 4'h0
                                             : r_div_cnt + 4'h1;

      if (estop) begin
        // Immediate, not period-aligned; beats any completing update.
        r_duty  <= 8'h00;
        r_tgt   <= 8'h00;
        r_state <= S_STOP;
        r_rdy   <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE, S_HOLD: begin
            r_rdy <= 1'b1;
            if (w_acc) begin
              r_tgt <= tgt_duty;
              if (tgt_duty > r_duty) begin
                r_state <= S_UP;
                r_rdy   <= 1'b0;
              end else if (tgt_duty < r_duty) begin
                r_state <= S_DOWN;
                r_rdy   <= 1'b0;
              end else begin
                r_state <= S_HOLD;
                r_done  <= 1'b1;
              end
            end
          end
          S_UP: begin
            if (w_upd) begin
              if (w_up_gap <= w_step9) begin
                r_duty  <= r_tgt;
                r_state <= S_HOLD;
                r_done  <= 1'b1;
                r_rdy   <= 1'b1;
              end else begin
                r_duty <= r_duty + STEP;
              end
            end
          end
          S_DOWN: begin
            if (w_upd) begin
              if (w_dn_gap <= w_step9) begin
                r_duty  <= r_tgt;
                r_state <= S_HOLD;
                r_done  <= 1'b1;
                r_rdy   <= 1'b1;
              end else begin
                r_duty <= r_duty - STEP;
              end
            end
          end
          S_STOP: begin
            // One IDLE cycle with rdy low before accepting again.
            r_state <= S_IDLE;
            r_rdy   <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_rdy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tgt_rdy  = r_rdy && !estop;
  assign duty     = r_duty;
  assign done     = r_done;
  assign prd_tick = w_tick;
  assign ramping  = (r_state == S_UP) || (r_state == S_DOWN);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: one instance at RATE_DIV=1,
// one at RATE_DIV=4, both with STEP=16.
module tb_pwm_ramp_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, vld1, est1, rdy1, rmp1, dn1, tk1;
  logic [7:0] tgt1, duty1;
  logic       rst4, vld4, est4, rdy4, rmp4, dn4, tk4;
  logic [7:0] tgt4, duty4;

  pwm_ramp_ctrl #(.STEP(8'd16), .RATE_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst1),
    .tgt_duty(tgt1), .tgt_vld(vld1), .tgt_rdy(rdy1),
    .estop(est1), .duty(duty1), .ramping(rmp1),
    .done(dn1), .prd_tick(tk1)
  );

  pwm_ramp_ctrl #(.STEP(8'd16), .RATE_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst4),
    .tgt_duty(tgt4), .tgt_vld(vld4), .tgt_rdy(rdy4),
    .estop(est4), .duty(duty4), .ramping(rmp4),
    .done(dn4), .prd_tick(tk4)
  );

  int n_run  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic get(input bit sel, output logic [7:0] d,
                     output logic r, output logic dn,
                     output logic rp);
    if (sel) begin
      d = duty4; r = rdy4; dn = dn4; rp = rmp4;
    end else begin
      d = duty1; r = rdy1; dn = dn1; rp = rmp1;
    end
  endtask

  task automatic wait_chg(input bit sel, input logic [7:0] prev,
                          input int max, output int n,
                          output logic early);
    logic [7:0] d;
    logic r, dn, rp;
    n = 0;
    early = 1'b0;
    do begin
      tick();
      n++;
      get(sel, d, r, dn, rp);
      if (d == prev && dn) early = 1'b1;
    end while (d == prev && n < max);
  endtask

  task automatic run_ramp(input bit sel, input string tg,
                          input logic [7:0] start,
                          input int intv, input bit fin);
    logic [7:0] prev, d;
    logic r, dn, rp, early, last;
    int n;
    prev = start;
    for (int i = 0; i < exp_q.size(); i++) begin
      wait_chg(sel, prev, intv + 400, n, early);
      get(sel, d, r, dn, rp);
      last = fin && (i == exp_q.size() - 1);
      chk({tg, " duty"}, d, exp_q[i]);
      if (i > 0) chk({tg, " intv"}, n, intv);
      chk({tg, " early done"}, early, 0);
      chk({tg, " done"}, dn, last);
      chk({tg, " ramping"}, rp, !last);
      if (last) chk({tg, " rdy"}, r, 1);
      prev = exp_q[i];
    end
    exp_q.delete();
  endtask

  int n;

  initial begin
    rst1 = 1; vld1 = 0; est1 = 0; tgt1 = 0;
    rst4 = 1; vld4 = 0; est4 = 0; tgt4 = 0;
    tick();
    tick();
    chk("rst duty", duty1, 8'h00);
    chk("rst rdy", rdy1, 0);
    chk("rst ramp", rmp1, 0);
    chk("rst done", dn1, 0);
    chk("rst tick", tk1, 0);
    chk("rst duty4", duty4, 8'h00);
    rst1 = 0; rst4 = 0;
    tick();
    chk("rel rdy", rdy1, 1);
    chk("rel rdy4", rdy4, 1);

    // RATE_DIV=4: clamp on the way up, then ramp down
    vld4 = 1; tgt4 = 8'h45;
    tick();
    vld4 = 0;
    chk("up45 acc", rmp4, 1);
    chk("up45 rdy", rdy4, 0);
    exp_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h45};
    run_ramp(1, "up45", 8'h00, 1024, 1);
    tick();
    chk("up45 done1", dn4, 0);
    vld4 = 1; tgt4 = 8'h03;
    tick();
    vld4 = 0;
    chk("dn03 acc", rmp4, 1);
    exp_q = '{8'h35, 8'h25, 8'h15, 8'h05, 8'h03};
    run_ramp(1, "dn03", 8'h45, 1024, 1);
    tick();
    chk("dn03 done1", dn4, 0);

    // RATE_DIV=1: exact-multiple ramp up
    vld1 = 1; tgt1 = 8'h40;
    tick();
    vld1 = 0;
    chk("up40 ramp", rmp1, 1);
    chk("up40 rdy", rdy1, 0);
    exp_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_ramp(0, "up40", 8'h00, 256, 1);
    tick();
    chk("up40 done1", dn1, 0);

    // Target held valid during a ramp waits for HOLD
    vld1 = 1; tgt1 = 8'h60;
    tick();
    tgt1 = 8'h80;
    chk("hs busy rdy", rdy1, 0);
    exp_q = '{8'h50, 8'h60};
    run_ramp(0, "hs60", 8'h40, 256, 1);
    tick();
    vld1 = 0;
    chk("hs acc ramp", rmp1, 1);
    chk("hs acc duty", duty1, 8'h60);
    exp_q = '{8'h70, 8'h80};
    run_ramp(0, "hs80", 8'h60, 256, 1);
    tick();

    // Equal target: HOLD, done next cycle, duty unchanged
    vld1 = 1; tgt1 = 8'h80;
    tick();
    vld1 = 0;
    chk("eq done", dn1, 1);
    chk("eq ramp", rmp1, 0);
    chk("eq duty", duty1, 8'h80);
    chk("eq rdy", rdy1, 1);
    tick();
    chk("eq done1", dn1, 0);

    // Emergency stop mid-ramp, off boundary
    vld1 = 1; tgt1 = 8'h00;
    tick();
    vld1 = 0;
    exp_q = '{8'h70, 8'h60, 8'h50, 8'h40, 8'h30};
    run_ramp(0, "esdn", 8'h80, 256, 0);
    repeat (10) tick();
    est1 = 1;
    tick();
    chk("es duty", duty1, 8'h00);
    chk("es rdy", rdy1, 0);
    chk("es ramp", rmp1, 0);
    chk("es done", dn1, 0);
    tick();
    est1 = 0;
    tick();
    chk("es idle rdy", rdy1, 0);
    chk("es idle done", dn1, 0);
    tick();
    chk("es rdy back", rdy1, 1);
    chk("es no done", dn1, 0);

    // estop on the completing update edge
    vld1 = 1; tgt1 = 8'h10;
    tick();
    vld1 = 0;
    n = 0;
    while (!tk1 && n < 400) begin
      tick();
      n++;
    end
    chk("sim align", tk1, 1);
    est1 = 1;
    tick();
    chk("sim duty", duty1, 8'h00);
    chk("sim done", dn1, 0);
    chk("sim ramp", rmp1, 0);
    tick();
    chk("sim done2", dn1, 0);
    est1 = 0;
    tick();
    tick();

    // rst overrides estop and lands in IDLE
    est1 = 1; rst1 = 1;
    tick();
    chk("rst+es duty", duty1, 8'h00);
    chk("rst+es ramp", rmp1, 0);
    est1 = 0; rst1 = 0;
    tick();
    chk("rst+es rdy", rdy1, 1);

    // Reset mid-operation at duty 0x30
    vld1 = 1; tgt1 = 8'h30;
    tick();
    vld1 = 0;
    exp_q = '{8'h10, 8'h20, 8'h30};
    run_ramp(0, "up30", 8'h00, 256, 1);
    repeat (5) tick();
    rst1 = 1;
    tick();
    tick();
    chk("mid rst duty", duty1, 8'h00);
    chk("mid rst rdy", rdy1, 0);
    chk("mid rst ramp", rmp1, 0);
    chk("mid rst done", dn1, 0);
    rst1 = 0;
    tick();
    chk("mid rel rdy", rdy1, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
